// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word, range-checks
// the immediate, and streams legal words with a word address to the imem write port.
module instr_encoder #(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd_addr,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  input  logic [6:0]        funct7,
  input  logic [31:0]       immediate,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_cnt
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMEM_DEPTH - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [31:0]       word;
  logic              legal;
  logic              accept;
  logic              load;
  logic              reject;
  logic              out_xfer;
  logic signed [31:0] imm_s;

  assign imm_s     = immediate;
  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign load      = accept && legal;
  assign reject    = accept && !legal;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    word  = 32'd0;
    legal = 1'b0;
    case (fmt)
      FMT_R: begin
        word  = {funct7, rs2_addr, rs1_addr, funct3, rd_addr, opcode};
        legal = 1'b1;
      end
      FMT_I: begin
        word  = {immediate[11:0], rs1_addr, funct3, rd_addr, opcode};
        legal = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
      end
      FMT_S: begin
        word  = {immediate[11:5], rs2_addr, rs1_addr, funct3, immediate[4:0], opcode};
        legal = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
      end
      FMT_B: begin
        word  = {immediate[12], immediate[10:5], rs2_addr, rs1_addr, funct3,
                 immediate[4:1], immediate[11], opcode};
        legal = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !immediate[0];
      end
      FMT_U: begin
        word  = {immediate[31:12], rd_addr, opcode};
        legal = (immediate[11:0] == 12'd0);
      end
      FMT_J: begin
        word  = {immediate[20], immediate[10:1], immediate[11], immediate[19:12],
                 rd_addr, opcode};
        legal = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !immediate[0];
      end
      default: begin
        word  = 32'd0;
        legal = 1'b0;
      end
    endcase
  end

  // Rejected bundles leave the output register alone; only a legal load replaces it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_instr <= 32'd0;
      out_addr  <= '0;
    end else if (load) begin
      state     <= FULL;
      out_instr <= word;
      out_addr  <= addr_cnt;
    end else if (out_xfer) begin
      state     <= EMPTY;
    end
  end

  // start wins over a same-cycle increment; the word loaded that cycle already took the old address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt <= '0;
    end else if (start) begin
      addr_cnt <= '0;
    end else if (load) begin
      addr_cnt <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err     <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      err <= reject;
      if (reject && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder; a second instance with
// IMEM_DEPTH=4 shares the stimulus and is checked for address wrap and start.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  fmt = 3'd0;
  logic [6:0]  opcode = 7'd0;
  logic [4:0]  rd_addr = 5'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [4:0]  rs1_addr = 5'd0;
  logic [4:0]  rs2_addr = 5'd0;
  logic [6:0]  funct7 = 7'd0;
  logic [31:0] immediate = 32'd0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, err;
  logic [31:0] out_instr;
  logic [7:0]  out_addr;
  logic [7:0]  err_cnt;

  logic        in_ready4, out_valid4, err4;
  logic [31:0] out_instr4;
  logic [1:0]  out_addr4;
  logic [7:0]  err_cnt4;

  int compared = 0;
  int mismatched = 0;

  instr_encoder #(.IMEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd_addr(rd_addr), .funct3(funct3),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .funct7(funct7), .immediate(immediate),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err(err), .err_cnt(err_cnt)
  );

  instr_encoder #(.IMEM_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
    .fmt(fmt), .opcode(opcode), .rd_addr(rd_addr), .funct3(funct3),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .funct7(funct7), .immediate(immediate),
    .out_valid(out_valid4), .out_ready(out_ready), .out_instr(out_instr4),
    .out_addr(out_addr4), .err(err4), .err_cnt(err_cnt4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] f, input logic [6:0] op,
                               input logic [4:0] rd, input logic [2:0] f3,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [6:0] f7, input logic [31:0] imm);
    in_valid  = 1'b1;
    fmt       = f;
    opcode    = op;
    rd_addr   = rd;
    funct3    = f3;
    rs1_addr  = rs1;
    rs2_addr  = rs2;
    funct7    = f7;
    immediate = imm;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_instr", out_instr, 32'd0);
    checkOutput("rst_out_addr",  {24'd0, out_addr}, 32'd0);
    checkOutput("rst_err",       {31'd0, err}, 32'd0);
    checkOutput("rst_err_cnt",   {24'd0, err_cnt}, 32'd0);
    checkOutput("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    checkOutput("rst_err_cnt4",  {24'd0, err_cnt4}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: ADDI x1,x0,5
    $display("[TB] test 1: single ADDI");
    out_ready = 1'b1;
    applyStimulus(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
    tick();
    in_valid = 1'b0;
    checkOutput("t1_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("t1_instr", out_instr, 32'h00500093);
    checkOutput("t1_addr",  {24'd0, out_addr}, 32'd0);
    tick();
    checkOutput("t1_drained", {31'd0, out_valid}, 32'd0);

    // 2: continuous stream
    $display("[TB] test 2: streaming R/S/B/J");
    pulseReset();
    out_ready = 1'b1;
    applyStimulus(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    #1 checkOutput("t2_ready0", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("t2_add_instr", out_instr, 32'h002081B3);
    checkOutput("t2_add_addr",  {24'd0, out_addr}, 32'd0);
    applyStimulus(3'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8);
    #1 checkOutput("t2_ready1", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("t2_sw_instr", out_instr, 32'h0020A423);
    checkOutput("t2_sw_addr",  {24'd0, out_addr}, 32'd1);
    applyStimulus(3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFC);
    #1 checkOutput("t2_ready2", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("t2_beq_instr", out_instr, 32'hFE000EE3);
    checkOutput("t2_beq_addr",  {24'd0, out_addr}, 32'd2);
    applyStimulus(3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
    #1 checkOutput("t2_ready3", {31'd0, in_ready}, 32'd1);
    tick();
    checkOutput("t2_jal_instr", out_instr, 32'h001000EF);
    checkOutput("t2_jal_addr",  {24'd0, out_addr}, 32'd3);
    checkOutput("t2_jal_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    tick();
    checkOutput("t2_drained", {31'd0, out_valid}, 32'd0);

    // 3: illegal bundles
    $display("[TB] test 3: rejects");
    applyStimulus(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
    tick();
    checkOutput("t3_err_i",   {31'd0, err}, 32'd1);
    checkOutput("t3_valid_i", {31'd0, out_valid}, 32'd0);
    applyStimulus(3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3);
    tick();
    checkOutput("t3_err_b",   {31'd0, err}, 32'd1);
    checkOutput("t3_valid_b", {31'd0, out_valid}, 32'd0);
    applyStimulus(3'd7, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    tick();
    checkOutput("t3_err_f",   {31'd0, err}, 32'd1);
    checkOutput("t3_valid_f", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;
    tick();
    checkOutput("t3_err_low", {31'd0, err}, 32'd0);
    checkOutput("t3_err_cnt", {24'd0, err_cnt}, 32'd3);
    applyStimulus(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
    tick();
    checkOutput("t3_next_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("t3_next_addr",  {24'd0, out_addr}, 32'd4);

    // 4: backpressure while FULL
    $display("[TB] test 4: backpressure");
    out_ready = 1'b0;
    applyStimulus(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    #1 checkOutput("t4_ready_low", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("t4_hold_instr", out_instr, 32'h00500093);
      checkOutput("t4_hold_addr",  {24'd0, out_addr}, 32'd4);
      checkOutput("t4_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1 checkOutput("t4_ready_rel", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    checkOutput("t4_next_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("t4_next_instr", out_instr, 32'h002081B3);
    checkOutput("t4_next_addr",  {24'd0, out_addr}, 32'd5);
    tick();
    checkOutput("t4_drained", {31'd0, out_valid}, 32'd0);

    // 5: address wrap and start on the depth-4 instance
    $display("[TB] test 5: wrap and start");
    pulseReset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'(i));
      tick();
      checkOutput("t5_wrap_addr",  {30'd0, out_addr4}, 32'(i % 4));
      checkOutput("t5_wrap_instr", out_instr4, 32'h00000093 | (32'(i) << 20));
    end
    start = 1'b1;
    applyStimulus(3'd4, 7'h37, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000);
    tick();
    start = 1'b0;
    checkOutput("t5_start_addr4",  {30'd0, out_addr4}, 32'd1);
    checkOutput("t5_start_instr4", out_instr4, 32'h12345137);
    checkOutput("t5_start_addr",   {24'd0, out_addr}, 32'd5);
    applyStimulus(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd7);
    tick();
    in_valid = 1'b0;
    checkOutput("t5_after_addr4", {30'd0, out_addr4}, 32'd0);
    checkOutput("t5_after_addr",  {24'd0, out_addr}, 32'd0);
    tick();

    // 6: reset while FULL and stalled
    $display("[TB] test 6: reset mid-operation");
    applyStimulus(3'd7, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    tick();
    out_ready = 1'b0;
    applyStimulus(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd9);
    tick();
    in_valid = 1'b0;
    checkOutput("t6_full",    {31'd0, out_valid}, 32'd1);
    checkOutput("t6_err_pre", {24'd0, err_cnt}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_rst_valid",  {31'd0, out_valid}, 32'd0);
    checkOutput("t6_rst_errcnt", {24'd0, err_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    applyStimulus(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
    tick();
    in_valid = 1'b0;
    checkOutput("t6_first_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("t6_first_addr",  {24'd0, out_addr}, 32'd0);
    checkOutput("t6_first_instr", out_instr, 32'h00500093);
    checkOutput("t6_dut4_ready",  {31'd0, in_ready4}, 32'd1);
    checkOutput("t6_dut4_err",    {31'd0, err4}, 32'd0);
    checkOutput("t6_dut4_valid",  {31'd0, out_valid4}, 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
